bcd_interval_timer: RTL

BCD_INTERVAL_TIMER -- requirements
Module: bcd_interval_timer

---
 rtl/bcd_timer_pkg.sv | 20 ++
 rtl/bcd_digit.sv | 56 +++++
 rtl/bcd_interval_timer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD interval timer: FSM state encoding,
// BCD digit width, the largest legal digit value and a digit clamp helper.
package bcd_timer_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Non-decimal nibbles (A..F) are treated as 9.
   function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
      return (d > DIGIT_MAX) ? DIGIT_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the interval timer count.
// Ports:
//   clk, reset   : system clock, asynchronous active-low reset
//   ld, ld_val   : load the digit with ld_val (clamped to 9); wins over en
//   en           : carry/borrow in; step this digit by one
//   up           : 1 = increment, 0 = decrement
//   digit        : registered digit value
//   step_val     : value the digit takes if only en is applied
//   co           : carry (9->0) or borrow (0->9) out to the next digit
module bcd_digit
   import bcd_timer_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               ld,
   input  logic [DIGIT_W-1:0] ld_val,
   input  logic               en,
   input  logic               up,
   output logic [DIGIT_W-1:0] digit,
   output logic [DIGIT_W-1:0] step_val,
   output logic               co
);

   logic [DIGIT_W-1:0] digit_q, digit_d;

   always_comb begin
      step_val = digit_q;
      co       = 1'b0;
      if (en) begin
         if (up) begin
            if (digit_q >= DIGIT_MAX) begin
               step_val = '0;
               co       = 1'b1;
            end else begin
               step_val = digit_q + 4'd1;
            end
         end else begin
            if (digit_q == '0) begin
               step_val = DIGIT_MAX;
               co       = 1'b1;
            end else begin
               step_val = digit_q - 4'd1;
            end
         end
      end
      digit_d = ld ? clamp_digit(ld_val) : step_val;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) digit_q <= '0;
      else        digit_q <= digit_d;
   end

   assign digit = digit_q;

endmodule

// File: rtl/bcd_interval_timer.sv
// BCD interval timer: counts up from 0 to a loaded terminal value, or down
// from a loaded start value to 0, one count per prescaled tick, with pause,
// resume and optional automatic reload.
// Ports:
//   clk, reset          : system clock, asynchronous active-low reset
//   load, load_val      : strobe capturing the BCD reload value
//   mode, auto_reload   : direction (1 = down) and auto-restart, latched on start
//   start, pause        : run/resume/restart strobe, freeze strobe
//   count               : current BCD count
//   running, done       : state flags
//   expired             : one-cycle pulse each time the end value is reached
//
// state     | meaning
// ST_IDLE   | loaded or reset, waiting for start
// ST_RUN    | prescaler advancing, count steps on each tick
// ST_PAUSED | count and prescaler frozen until start
// ST_DONE   | end value reached without auto-reload, count held
module bcd_interval_timer
   import bcd_timer_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1,
   parameter int DIGITS  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*DIGITS-1:0]     load_val,
   input  logic                    mode,
   input  logic                    auto_reload,
   input  logic                    start,
   input  logic                    pause,
   output logic [4*DIGITS-1:0]     count,
   output logic                    running,
   output logic                    done,
   output logic                    expired
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam int CW  = DIGIT_W * DIGITS;

   state_e          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [CW-1:0]   reload_q, reload_d;
   logic            mode_q, mode_d;
   logic            ar_q, ar_d;
   logic            fresh_q, fresh_d;
   logic            expired_q, expired_d;

   logic [CW-1:0]   reload_clamped, end_val, start_val, count_step, cnt_ld_val;
   logic            cnt_ld, cnt_up, step_en, tick, at_end, msd_co;

   always_comb begin
      reload_clamped = '0;
      for (int i = 0; i < DIGITS; i++)
         reload_clamped[i*DIGIT_W +: DIGIT_W] = clamp_digit(load_val[i*DIGIT_W +: DIGIT_W]);
   end

   assign end_val   = mode_q ? '0 : reload_q;
   assign start_val = mode_q ? reload_q : '0;
   assign at_end    = (count == end_val);
   assign tick      = (state_q == ST_RUN) && (presc_q == PW'(DIV - 1));
   assign cnt_up    = ~mode_q;
   // A tick sitting on the end value reloads instead of stepping; a strobe
   // in the same cycle takes the cycle and suppresses counting.
   assign step_en   = tick && !at_end && !load && !pause;

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      logic en_in, co_out;
      if (i == 0) begin : g_lsd
         assign en_in = step_en;
      end else begin : g_chain
         assign en_in = g_dig[i-1].co_out;
      end
      bcd_digit u_digit (
         .clk      (clk),
         .reset    (reset),
         .ld       (cnt_ld),
         .ld_val   (cnt_ld_val[i*DIGIT_W +: DIGIT_W]),
         .en       (en_in),
         .up       (cnt_up),
         .digit    (count[i*DIGIT_W +: DIGIT_W]),
         .step_val (count_step[i*DIGIT_W +: DIGIT_W]),
         .co       (co_out)
      );
   end

   assign msd_co = g_dig[DIGITS-1].co_out;

   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      reload_d   = reload_q;
      mode_d     = mode_q;
      ar_d       = ar_q;
      fresh_d    = fresh_q;
      expired_d  = 1'b0;
      cnt_ld     = 1'b0;
      cnt_ld_val = start_val;
      if (load) begin
         reload_d   = reload_clamped;
         cnt_ld     = 1'b1;
         cnt_ld_val = mode ? reload_clamped : '0;
         presc_d    = '0;
         fresh_d    = 1'b0;
         state_d    = ST_IDLE;
      end else if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
         mode_d     = mode;
         ar_d       = auto_reload;
         cnt_ld     = 1'b1;
         cnt_ld_val = mode ? reload_q : '0;
         presc_d    = '0;
         fresh_d    = 1'b1;
         state_d    = ST_RUN;
      end else if (start && state_q == ST_PAUSED) begin
         state_d = ST_RUN;
      end else if (pause && state_q == ST_RUN) begin
         state_d = ST_PAUSED;
      end else if (state_q == ST_RUN) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         fresh_d = 1'b0;
         // fresh_q marks the first running cycle after a (re)start, so a run
         // that starts on its end value expires without waiting for a tick.
         if (fresh_q && at_end) begin
            expired_d = 1'b1;
         end else if (tick) begin
            if (at_end) begin
               cnt_ld    = 1'b1;
               expired_d = (start_val == end_val);
            end else begin
               // A carry out of the top digit would be a wrap; end the run.
               expired_d = (count_step == end_val) || msd_co;
            end
         end
         if (expired_d && !ar_q) state_d = ST_DONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         reload_q  <= '0;
         mode_q    <= 1'b0;
         ar_q      <= 1'b0;
         fresh_q   <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         reload_q  <= reload_d;
         mode_q    <= mode_d;
         ar_q      <= ar_d;
         fresh_q   <= fresh_d;
         expired_q <= expired_d;
      end
   end

   assign running = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);
   assign expired = expired_q;

endmodule
